rst_seq_rx: RTL and testbench

- Consumer end of the testbench clock/reset interface: takes the free-running `clk` and the raw asynchronous active-low `reset`, and turns them into clean, sequenced resets for the design.
- Reset assertion is immediate (asynchronous); release is synchronized to `clk`, then staged across NSTAGE downstream domains.
- Signals `ready` when every stage is released and supports a software-requested re-sequence.
- Instantiated once per DUT top, between the clock/reset generator and the counter datapath.

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_seq_rx_if.sv | 23 ++
 rtl/rst_sync.sv | 24 ++
 rtl/rst_seq_rx.sv | 135 +++++++++++++
 tb/tb_rst_seq_rx.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// delay-counter width and default parameter values.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam int DCNT_W          = 8;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_NSTAGE      = 3;
  localparam int DEF_STAGE_DLY   = 4;
  localparam int DEF_HOLD_CYC    = 8;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/rst_seq_rx_if.sv
// Reset-sequencer bundle: soft-reset handshake plus the sequenced reset outputs.
// master = the sequencer (drives resets/status), slave = the consumer (drives the request).
interface rst_seq_rx_if #(
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 16
);
  logic              soft_rst_req;
  logic              rst_sync_n;
  logic [NSTAGE-1:0] stage_rst_n;
  logic              ready;
  logic              soft_rst_ack;
  logic [CNT_W-1:0]  cyc_cnt;

  modport master (
    input  soft_rst_req,
    output rst_sync_n, stage_rst_n, ready, soft_rst_ack, cyc_cnt
  );

  modport slave (
    output soft_rst_req,
    input  rst_sync_n, stage_rst_n, ready, soft_rst_ack, cyc_cnt
  );
endinterface

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer, SYNC_STAGES flops deep.
// Latency: rst_sync_n rises on the SYNC_STAGES-th edge sampling reset=1; no backpressure.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_rx.sv
// Reset sequencer: synchronizes reset release, then frees NSTAGE resets STAGE_DLY apart; supports soft re-sequence.
// Stage k frees (k+1)*STAGE_DLY edges after rst_sync_n; no backpressure. Uptime counter built only with RST_SEQ_RX_UPTIME_EN.
module rst_seq_rx
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NSTAGE      = DEF_NSTAGE,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  rst_seq_rx_if.master rx
);

  localparam int SIDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [DCNT_W-1:0] DLY_LAST  = DCNT_W'(STAGE_DLY - 1);
  localparam logic [DCNT_W-1:0] HOLD_LAST = DCNT_W'(HOLD_CYC - 1);

  logic              rst_sync_n;
  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [DCNT_W-1:0] hcnt_q, hcnt_d;
  logic [SIDX_W-1:0] sidx_q, sidx_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              ack_q, ack_d;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .rst_sync_n (rst_sync_n)
  );

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    sidx_d  = sidx_q;
    stage_d = stage_q;
    ack_d   = 1'b0;
    case (state_q)
      SYNC: begin
        // The edge leaving SYNC already counts as the first delay edge, so stage k
        // lands exactly (k+1)*STAGE_DLY edges after rst_sync_n rises.
        if (rst_sync_n) begin
          state_d = RELEASE;
          sidx_d  = '0;
          if (DLY_LAST == '0) begin
            stage_d[0] = 1'b1;
            sidx_d     = SIDX_W'(1);
            dcnt_d     = '0;
          end else begin
            dcnt_d = DCNT_W'(1);
          end
        end
      end
      RELEASE: begin
        if (&stage_q) begin
          state_d = RUN;
        end else if (dcnt_q == DLY_LAST) begin
          stage_d[sidx_q] = 1'b1;
          dcnt_d          = '0;
          sidx_d          = sidx_q + SIDX_W'(1);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      RUN: begin
        if (rx.soft_rst_req) begin
          state_d = HOLD;
          stage_d = '0;
          ack_d   = 1'b1;
          dcnt_d  = '0;
          hcnt_d  = '0;
        end
      end
      HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          dcnt_d  = '0;
          sidx_d  = '0;
        end else begin
          hcnt_d = hcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      sidx_q  <= '0;
      stage_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      sidx_q  <= sidx_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
    end
  end

  assign rx.rst_sync_n   = rst_sync_n;
  assign rx.stage_rst_n  = stage_q;
  assign rx.ready        = (state_q == RUN);
  assign rx.soft_rst_ack = ack_q;

`ifdef RST_SEQ_RX_UPTIME_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == RUN) begin
      if (rx.soft_rst_req)       cyc_cnt_d = '0;
      else if (cyc_cnt_q != '1)  cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end

  assign rx.cyc_cnt = cyc_cnt_q;
`else
  assign rx.cyc_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rst_seq_rx.sv
// Directed bench for rst_seq_rx: vector table for power-up/uptime/soft reset,
// hand sequences for ignored requests, async mid-sequence reset and counter saturation.
module tb_rst_seq_rx;

`ifdef RST_SEQ_RX_UPTIME_EN
  localparam bit UPT_EN = 1'b1;
`else
  localparam bit UPT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rst_seq_rx_if #(.NSTAGE(3), .CNT_W(16)) rx ();
  rst_seq_rx_if #(.NSTAGE(3), .CNT_W(4))  rx_sat ();

  rst_seq_rx u_dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx)
  );

  rst_seq_rx #(.CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_sat)
  );

  typedef struct {
    logic       rst;
    logic       req;
    int         adv;
    logic       sync;
    logic [2:0] stg;
    logic       rdy;
    logic       ack;
    int         cyc;
  } vec_t;

  vec_t tbl [18];

  function automatic int exp_c(input int v);
    return UPT_EN ? v : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic sync, input logic [2:0] stg,
                         input logic rdy, input logic ack, input int cyc);
    logic [2:0] s;
    s = rx.stage_rst_n;
    chk({nm, ".sync"},  32'(rx.rst_sync_n),   32'(sync));
    chk({nm, ".stage"}, 32'(rx.stage_rst_n),  32'(stg));
    chk({nm, ".ready"}, 32'(rx.ready),        32'(rdy));
    chk({nm, ".ack"},   32'(rx.soft_rst_ack), 32'(ack));
    chk({nm, ".cyc"},   32'(rx.cyc_cnt),      32'(cyc));
    chk({nm, ".inv_order"}, 32'((s & (s + 3'd1)) == 3'd0), 32'd1);
    chk({nm, ".inv_ready"}, 32'(!rx.ready || (s == 3'b111)), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset and walk the sequence up to edge stop_at after rst_sync_n rises.
  task automatic release_seq(input string nm, input bit req_during, input int stop_at);
    logic [2:0] es;
    reset = 1'b1;
    step(1);
    chk({nm, ".sync_lo"}, 32'(rx.rst_sync_n), 32'd0);
    step(1);
    chk({nm, ".sync_hi"}, 32'(rx.rst_sync_n), 32'd1);
    rx.soft_rst_req = req_during;
    for (int e = 1; e <= stop_at; e++) begin
      step(1);
      if (e == 11) rx.soft_rst_req = 1'b0;
      es = (e >= 12) ? 3'b111 : (e >= 8) ? 3'b011 : (e >= 4) ? 3'b001 : 3'b000;
      chk_all($sformatf("%s.e%0d", nm, e), 1'b1, es, (e >= 13), 1'b0, 0);
    end
  endtask

  initial begin
    rx.soft_rst_req     = 1'b0;
    rx_sat.soft_rst_req = 1'b0;

    //            rst   req  adv sync stg     rdy  ack  cyc
    tbl[0]  = '{1'b0, 1'b0,  3, 1'b0, 3'b000, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0,  1, 1'b0, 3'b000, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0,  1, 1'b1, 3'b000, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0,  3, 1'b1, 3'b000, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0,  1, 1'b1, 3'b001, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0,  3, 1'b1, 3'b001, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0,  1, 1'b1, 3'b011, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 1'b0,  4, 1'b1, 3'b111, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0,  1, 1'b1, 3'b111, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 20, 1'b1, 3'b111, 1'b1, 1'b0, 20};
    tbl[10] = '{1'b1, 1'b1,  1, 1'b1, 3'b000, 1'b0, 1'b1, 0};
    tbl[11] = '{1'b1, 1'b0,  1, 1'b1, 3'b000, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 10, 1'b1, 3'b000, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0,  1, 1'b1, 3'b001, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b0,  4, 1'b1, 3'b011, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0,  4, 1'b1, 3'b111, 1'b0, 1'b0, 0};
    tbl[16] = '{1'b1, 1'b0,  1, 1'b1, 3'b111, 1'b1, 1'b0, 0};
    tbl[17] = '{1'b1, 1'b0,  1, 1'b1, 3'b111, 1'b1, 1'b0, 1};

    // Async assert from time zero, well before the first clock edge.
    #2 reset = 1'b0;
    #1 chk_all("por_async", 1'b0, 3'b000, 1'b0, 1'b0, 0);

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      reset           = tbl[i].rst;
      rx.soft_rst_req = tbl[i].req;
      step(tbl[i].adv);
      chk_all($sformatf("v%0d", i), tbl[i].sync, tbl[i].stg, tbl[i].rdy,
              tbl[i].ack, exp_c(tbl[i].cyc));
    end

    // The 4-bit-counter instance has sat in RUN for well over 15 cycles.
    chk("sat.ready", 32'(rx_sat.ready),   32'd1);
    chk("sat.cyc",   32'(rx_sat.cyc_cnt), 32'(exp_c(15)));
    step(3);
    chk("sat.hold",  32'(rx_sat.cyc_cnt), 32'(exp_c(15)));

    // Request held through RELEASE is ignored and does not disturb timing.
    reset = 1'b0;
    #1 chk_all("ign_rst", 1'b0, 3'b000, 1'b0, 1'b0, 0);
    step(2);
    release_seq("ign", 1'b1, 13);
    step(5);
    chk("ign.cyc5", 32'(rx.cyc_cnt), 32'(exp_c(5)));

    // Reset dropped between stage 1 and stage 2 release, away from any clock edge.
    reset = 1'b0;
    step(2);
    release_seq("mid", 1'b0, 10);
    #2 reset = 1'b0;
    #1 chk_all("mid_async", 1'b0, 3'b000, 1'b0, 1'b0, 0);
    chk("mid_async.sat_stage", 32'(rx_sat.stage_rst_n), 32'd0);
    step(2);
    release_seq("restart", 1'b0, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
